// File: rtl/text_tile_gen.sv
// Text-mode tile generator: COLS x ROWS tile RAM with write cursor, clear sweep and blinking
// cursor, rendered through a 3-stage pixel pipeline using a built-in 8x16 glyph ROM.
module text_tile_gen #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter logic [2:0]  FG_RGB    = 3'b010,
  parameter logic [2:0]  BG_RGB    = 3'b000,
  parameter int unsigned BLINK_CYC = 25000000,
  localparam int unsigned XW       = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned YW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_en,
  input  logic [1:0]    cmd,
  input  logic [6:0]    wr_char,
  output logic          busy,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          text_on,
  output logic [2:0]    rgb_text
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned BW    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [1:0] CMD_PUT   = 2'b00;
  localparam logic [1:0] CMD_NL    = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_HOME  = 2'b11;

  // Glyph rows, row 0 in the most significant byte, bit 7 is the leftmost pixel.
  localparam logic [127:0] GLYPH_A = {8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                      8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [127:0] GLYPH_B = {8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h66,
                                      8'h66, 8'h66, 8'h66, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic logic [7:0] glyph_row(input logic [6:0] ch, input logic [3:0] r);
    logic [7:0] row_bits;
    row_bits = 8'h00;
    case (ch)
      7'h41:   row_bits = GLYPH_A[{~r, 3'b000} +: 8];
      7'h42:   row_bits = GLYPH_B[{~r, 3'b000} +: 8];
      default: row_bits = 8'h00;
    endcase
    return row_bits;
  endfunction

  // ---------------------------------------------------------------------------
  // Command FSM and cursor
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [AW-1:0] cur_addr;

  assign cur_addr = AW'(32'(cur_y_q) * COLS + 32'(cur_x_q));

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    wr_we      = 1'b0;
    wr_addr    = cur_addr;
    wr_data    = wr_char;
    case (state_q)
      ST_CLEAR: begin
        wr_we   = 1'b1;
        wr_addr = clr_addr_q;
        wr_data = 7'h00;
        if (clr_addr_q == AW'(CELLS - 1)) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
          cur_x_d    = '0;
          cur_y_d    = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        if (wr_en) begin
          case (cmd)
            CMD_PUT: begin
              wr_we = 1'b1;
              if (cur_x_q == XW'(COLS - 1)) begin
                cur_x_d = '0;
                cur_y_d = (cur_y_q == YW'(ROWS - 1)) ? '0 : cur_y_q + YW'(1);
              end else begin
                cur_x_d = cur_x_q + XW'(1);
              end
            end
            CMD_NL: begin
              cur_x_d = '0;
              cur_y_d = (cur_y_q == YW'(ROWS - 1)) ? '0 : cur_y_q + YW'(1);
            end
            CMD_CLEAR: begin
              state_d    = ST_CLEAR;
              clr_addr_d = '0;
            end
            CMD_HOME: begin
              cur_x_d = '0;
              cur_y_d = '0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
    end
  end

  assign busy  = (state_q == ST_CLEAR);
  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;

  // ---------------------------------------------------------------------------
  // Cursor blink
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Tile RAM: separate read and write processes give read-before-write on collision.
  // ---------------------------------------------------------------------------
  logic [6:0]    tile_mem [CELLS];
  logic [6:0]    tile_q;
  logic [6:0]    pix_col;
  logic [5:0]    pix_row;
  logic          in_area;
  logic          cursor_hit;
  logic [AW-1:0] rd_addr;

  assign pix_col    = pixel_x[9:3];
  assign pix_row    = pixel_y[9:4];
  assign in_area    = (32'(pix_col) < COLS) && (32'(pix_row) < ROWS);
  assign rd_addr    = in_area ? AW'(32'(pix_row) * COLS + 32'(pix_col)) : '0;
  assign cursor_hit = in_area && (32'(pix_col) == 32'(cur_x_q)) && (32'(pix_row) == 32'(cur_y_q));

  always_ff @(posedge clk) begin
    if (wr_we) tile_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    tile_q <= tile_mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline: S1 tile read, S2 glyph read, S3 output register.
  // ---------------------------------------------------------------------------
  logic [2:0] bit_s1, bit_s2;
  logic [3:0] row_s1;
  logic       von_s1, von_s2;
  logic       area_s1, area_s2;
  logic       curs_s1, curs_s2;
  logic [7:0] font_q;
  logic       lit;

  always_ff @(posedge clk) begin
    font_q <= glyph_row(tile_q, row_s1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_s1  <= '0;
      row_s1  <= '0;
      von_s1  <= 1'b0;
      area_s1 <= 1'b0;
      curs_s1 <= 1'b0;
      bit_s2  <= '0;
      von_s2  <= 1'b0;
      area_s2 <= 1'b0;
      curs_s2 <= 1'b0;
    end else begin
      bit_s1  <= pixel_x[2:0];
      row_s1  <= pixel_y[3:0];
      von_s1  <= video_on;
      area_s1 <= in_area;
      curs_s1 <= cursor_hit && blink_phase_q && !busy;
      bit_s2  <= bit_s1;
      von_s2  <= von_s1;
      area_s2 <= area_s1;
      curs_s2 <= curs_s1;
    end
  end

  assign lit = font_q[~bit_s2] ^ curs_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_text <= 3'b000;
      text_on  <= 1'b0;
    end else if (!von_s2) begin
      rgb_text <= 3'b000;
      text_on  <= 1'b0;
    end else if (!area_s2) begin
      rgb_text <= BG_RGB;
      text_on  <= 1'b0;
    end else begin
      rgb_text <= lit ? FG_RGB : BG_RGB;
      text_on  <= lit;
    end
  end

endmodule

// File: tb/tb_text_tile_gen.sv
// Directed bench for text_tile_gen: clear sweep, cursor moves, glyph pixels, blink and blanking.
module tb_text_tile_gen;

  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] BG = 3'b101;
  localparam int CELLS = 80 * 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] pixel_x, pixel_y;
  logic       wr_en;
  logic [1:0] cmd;
  logic [6:0] wr_char;
  logic       busy;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       text_on;
  logic [2:0] rgb_text;

  int checks = 0;
  int errors = 0;

  text_tile_gen #(
    .COLS     (80),
    .ROWS     (30),
    .FG_RGB   (FG),
    .BG_RGB   (BG),
    .BLINK_CYC(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .video_on(video_on),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .wr_en   (wr_en),
    .cmd     (cmd),
    .wr_char (wr_char),
    .busy    (busy),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .text_on (text_on),
    .rgb_text(rgb_text)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [6:0] ch);
    @(negedge clk);
    wr_en   = 1'b1;
    cmd     = c;
    wr_char = ch;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y, input logic von);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input logic von,
                           input logic [2:0] exp_rgb, input logic exp_on);
    set_pix(x, y, von);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_rgb"}, 32'(rgb_text), 32'(exp_rgb));
    chk({tag, "_on"}, 32'(text_on), 32'(exp_on));
  endtask

  // Counts cycles with busy high starting at the current negedge, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int first;
    int lit_cnt;
    logic s [20];

    reset = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    wr_en = 1'b0; cmd = 2'b00; wr_char = 7'h00;

    // Reset state and initial clear sweep
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_cur_x", 32'(cur_x), 0);
    chk("rst_cur_y", 32'(cur_y), 0);
    chk("rst_rgb", 32'(rgb_text), 0);
    chk("rst_text_on", 32'(text_on), 0);
    reset = 1'b0;
    count_busy(n);
    chk("init_sweep_len", 32'(n), 32'(CELLS));
    chk("init_cur_x", 32'(cur_x), 0);
    chk("init_cur_y", 32'(cur_y), 0);
    check_pix("blank_screen", 40, 40, 1'b1, BG, 1'b0);

    // Blink on blank cursor cell (0,0): text_on toggles every 4 cycles
    set_pix(0, 0, 1'b1);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      #1 s[i] = text_on;
      @(posedge clk);
    end
    first = -1;
    for (int i = 1; i <= 8; i++) if (first < 0 && s[i] != s[i-1]) first = i;
    chk("blink_toggles", 32'(first >= 0), 1);
    if (first >= 0)
      for (int j = first + 1; j < 20; j++)
        chk("blink_period", 32'(s[j] != s[j-1]), 32'(((j - first) % 4) == 0));

    // Clear: no cursor while busy, writes ignored
    do_cmd(2'b10, 7'h00);
    chk("clear_busy", 32'(busy), 1);
    repeat (4) @(negedge clk);
    lit_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (text_on) lit_cnt++;
      @(negedge clk);
    end
    chk("busy_no_cursor", 32'(lit_cnt), 0);
    do_cmd(2'b00, 7'h41);
    chk("busy_put_x", 32'(cur_x), 0);
    do_cmd(2'b01, 7'h00);
    chk("busy_nl_y", 32'(cur_y), 0);
    count_busy(n);
    chk("clear_done", 32'(busy), 0);

    // Put 'A', 'B' and check glyph pixels
    do_cmd(2'b00, 7'h41);
    do_cmd(2'b00, 7'h42);
    chk("ab_cur_x", 32'(cur_x), 2);
    chk("ab_cur_y", 32'(cur_y), 0);
    check_pix("a_r2_x3", 3, 2, 1'b1, FG, 1'b1);
    check_pix("a_r2_x0", 0, 2, 1'b1, BG, 1'b0);
    check_pix("a_r7_x1", 1, 7, 1'b1, FG, 1'b1);
    check_pix("a_r7_x7", 7, 7, 1'b1, BG, 1'b0);
    check_pix("a_r0_x3", 3, 0, 1'b1, BG, 1'b0);
    check_pix("b_r2_x8", 8, 2, 1'b1, FG, 1'b1);
    check_pix("b_r2_x14", 14, 2, 1'b1, BG, 1'b0);
    check_pix("b_r6_x10", 10, 6, 1'b1, FG, 1'b1);

    // Blanking and out-of-area
    check_pix("von_off", 3, 2, 1'b0, 3'b000, 1'b0);
    check_pix("col_out", 640, 2, 1'b1, BG, 1'b0);
    check_pix("row_out", 3, 480, 1'b1, BG, 1'b0);

    // Cursor movement boundaries
    do_cmd(2'b01, 7'h00);
    chk("nl_x", 32'(cur_x), 0);
    chk("nl_y", 32'(cur_y), 1);
    do_cmd(2'b11, 7'h00);
    chk("home_y", 32'(cur_y), 0);
    for (int i = 0; i < 80; i++) do_cmd(2'b00, 7'h42);
    chk("row_wrap_x", 32'(cur_x), 0);
    chk("row_wrap_y", 32'(cur_y), 1);
    do_cmd(2'b11, 7'h00);
    for (int i = 0; i < 29; i++) do_cmd(2'b01, 7'h00);
    for (int i = 0; i < 79; i++) do_cmd(2'b00, 7'h41);
    chk("last_cell_x", 32'(cur_x), 79);
    chk("last_cell_y", 32'(cur_y), 29);
    do_cmd(2'b00, 7'h41);
    chk("screen_wrap_x", 32'(cur_x), 0);
    chk("screen_wrap_y", 32'(cur_y), 0);
    for (int i = 0; i < 29; i++) do_cmd(2'b01, 7'h00);
    chk("nl_row29", 32'(cur_y), 29);
    do_cmd(2'b01, 7'h00);
    chk("nl_wrap_y", 32'(cur_y), 0);

    // Reset in the middle of a clear sweep restarts it
    do_cmd(2'b10, 7'h00);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("mid_clear_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    chk("restart_sweep_len", 32'(n), 32'(CELLS));
    chk("restart_cur_x", 32'(cur_x), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
